mc_ctrl: RTL and testbench

Multi-cycle control FSM for the MIPS-subset CPU. It sequences the program-counter register, the instruction register, the GRF, the ALU and the data memory through FETCH/DECODE/EXEC/MEM/WB. It is the only source of the PC write enable and the next-PC select. It sits between the IR output and every datapath enable and mux select, and keeps a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 64 ++++++
 rtl/mc_ctrl_decode.sv | 46 ++++
 rtl/mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset controller: state codes,
// datapath select encodings, opcode/funct constants and instruction classes.
package mc_ctrl_pkg;

    localparam logic [31:0] PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_t;

    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JUMP   = 2'd2;
    localparam logic [1:0] NPC_REG    = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    localparam logic [1:0] WD_ALU = 2'd0;
    localparam logic [1:0] WD_MEM = 2'd1;
    localparam logic [1:0] WD_PC4 = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_OR  = 2'd2;
    localparam logic [1:0] ALU_LUI = 2'd3;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;

    // Bit positions of the one-hot instruction class vector.
    localparam int CLS_RCALC = 0;
    localparam int CLS_ORI   = 1;
    localparam int CLS_LUI   = 2;
    localparam int CLS_LW    = 3;
    localparam int CLS_SW    = 4;
    localparam int CLS_BEQ   = 5;
    localparam int CLS_J     = 6;
    localparam int CLS_JAL   = 7;
    localparam int CLS_JR    = 8;
    localparam int CLS_OTHER = 9;
    localparam int CLS_W     = 10;

    typedef logic [CLS_W-1:0] cls_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps a 32-bit instruction onto a
// one-hot class, plus the add/subtract distinction inside the R-type class.
import mc_ctrl_pkg::*;

module mc_ctrl_decode (
    input  logic [31:0] instr,
    output cls_t        cls,
    output logic        rcalc_sub
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_fields;

    assign opcode = instr[31:26];
    assign funct  = instr[5:0];
    // Register numbers and immediates do not influence control flow.
    assign unused_fields = ^instr[25:6];

    always_comb begin
        cls       = '0;
        rcalc_sub = 1'b0;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_ADDU: cls[CLS_RCALC] = 1'b1;
                    FN_SUBU: begin
                        cls[CLS_RCALC] = 1'b1;
                        rcalc_sub      = 1'b1;
                    end
                    FN_JR:   cls[CLS_JR] = 1'b1;
                    default: cls[CLS_OTHER] = 1'b1;
                endcase
            end
            OP_ORI:  cls[CLS_ORI] = 1'b1;
            OP_LUI:  cls[CLS_LUI] = 1'b1;
            OP_LW:   cls[CLS_LW]  = 1'b1;
            OP_SW:   cls[CLS_SW]  = 1'b1;
            OP_BEQ:  cls[CLS_BEQ] = 1'b1;
            OP_J:    cls[CLS_J]   = 1'b1;
            OP_JAL:  cls[CLS_JAL] = 1'b1;
            default: cls[CLS_OTHER] = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with retired-instruction
// counter. Define MC_CTRL_MEM_WAIT_EN to add mem_ready and stall in MEM.
import mc_ctrl_pkg::*;

module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic        mem_ready,
`endif
    output logic        pc_we,
    output logic [1:0]  npc_sel,
    output logic        ir_we,
    output logic        reg_we,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_sel,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        ext_op,
    output logic        mem_we,
    output logic [2:0]  state,
    output logic [31:0] instr_cnt
);

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] cnt_reg;
    cls_t        cls;
    logic        rcalc_sub;
    logic        mem_go;
    logic [1:0]  cls_alu_op;
    logic        cls_alu_src;
    logic        cls_ext_op;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    assign mem_go = 1'b1;
`endif

    mc_ctrl_decode u_decode (
        .instr     (instr),
        .cls       (cls),
        .rcalc_sub (rcalc_sub)
    );

    // ALU configuration per class; held through EXEC, MEM and WB.
    always_comb begin
        cls_alu_op  = ALU_ADD;
        cls_alu_src = 1'b0;
        cls_ext_op  = EXT_ZERO;
        if (cls[CLS_RCALC]) begin
            cls_alu_op = rcalc_sub ? ALU_SUB : ALU_ADD;
        end else if (cls[CLS_ORI]) begin
            cls_alu_op  = ALU_OR;
            cls_alu_src = 1'b1;
        end else if (cls[CLS_LUI]) begin
            cls_alu_op  = ALU_LUI;
            cls_alu_src = 1'b1;
        end else if (cls[CLS_LW] || cls[CLS_SW]) begin
            cls_alu_op  = ALU_ADD;
            cls_alu_src = 1'b1;
            cls_ext_op  = EXT_SIGN;
        end else if (cls[CLS_BEQ]) begin
            cls_alu_op = ALU_SUB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_FETCH;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (pc_we) begin
                cnt_reg <= cnt_reg + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = ST_FETCH;
        pc_we      = 1'b0;
        npc_sel    = NPC_PC4;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = DST_RT;
        wd_sel     = WD_ALU;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        ext_op     = EXT_ZERO;
        mem_we     = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                ir_we      = 1'b1;
                state_next = ST_DECODE;
            end
            ST_DECODE: begin
                if (cls[CLS_OTHER]) begin
                    pc_we      = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op  = cls_alu_op;
                alu_src = cls_alu_src;
                ext_op  = cls_ext_op;
                if (cls[CLS_RCALC] || cls[CLS_ORI] || cls[CLS_LUI]) begin
                    state_next = ST_WB;
                end else if (cls[CLS_LW] || cls[CLS_SW]) begin
                    state_next = ST_MEM;
                end else if (cls[CLS_BEQ]) begin
                    pc_we   = 1'b1;
                    npc_sel = zero ? NPC_BRANCH : NPC_PC4;
                end else if (cls[CLS_J]) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_JUMP;
                end else if (cls[CLS_JAL]) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_JUMP;
                    reg_we  = 1'b1;
                    reg_dst = DST_RA;
                    wd_sel  = WD_PC4;
                end else if (cls[CLS_JR]) begin
                    pc_we   = 1'b1;
                    npc_sel = NPC_REG;
                end
            end
            ST_MEM: begin
                alu_op  = cls_alu_op;
                alu_src = cls_alu_src;
                ext_op  = cls_ext_op;
                // A store keeps mem_we up for the whole stall and retires on the ready cycle.
                if (cls[CLS_SW]) begin
                    mem_we     = 1'b1;
                    pc_we      = mem_go;
                    state_next = mem_go ? ST_FETCH : ST_MEM;
                end else if (cls[CLS_LW]) begin
                    state_next = mem_go ? ST_WB : ST_MEM;
                end
            end
            ST_WB: begin
                alu_op  = cls_alu_op;
                alu_src = cls_alu_src;
                ext_op  = cls_ext_op;
                reg_we  = 1'b1;
                pc_we   = 1'b1;
                reg_dst = cls[CLS_RCALC] ? DST_RD : DST_RT;
                wd_sel  = cls[CLS_LW] ? WD_MEM : WD_ALU;
            end
            default: state_next = ST_FETCH;
        endcase

        // Reset abandons the current instruction: nothing may be written on that edge.
        if (reset) begin
            pc_we   = 1'b0;
            npc_sel = NPC_PC4;
            ir_we   = 1'b0;
            reg_we  = 1'b0;
            reg_dst = DST_RT;
            wd_sel  = WD_ALU;
            alu_src = 1'b0;
            alu_op  = ALU_ADD;
            ext_op  = EXT_ZERO;
            mem_we  = 1'b0;
        end
    end

    assign state     = state_reg;
    assign instr_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected outputs are queued with each
// instruction and checked against the DUT as the instruction executes.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic        zero;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic        mem_ready;
`endif
    logic        pc_we;
    logic [1:0]  npc_sel;
    logic        ir_we;
    logic        reg_we;
    logic [1:0]  reg_dst;
    logic [1:0]  wd_sel;
    logic        alu_src;
    logic [1:0]  alu_op;
    logic        ext_op;
    logic        mem_we;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [31:0] exp_cnt = '0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] we;   // {pc_we, ir_we, reg_we, mem_we}
        logic [9:0] sel;  // {npc_sel, reg_dst, wd_sel, alu_src, alu_op, ext_op}
        bit         rst;
        bit         rdy;
    } rec_t;

    rec_t sb[$];

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .zero      (zero),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready (mem_ready),
`endif
        .pc_we     (pc_we),
        .npc_sel   (npc_sel),
        .ir_we     (ir_we),
        .reg_we    (reg_we),
        .reg_dst   (reg_dst),
        .wd_sel    (wd_sel),
        .alu_src   (alu_src),
        .alu_op    (alu_op),
        .ext_op    (ext_op),
        .mem_we    (mem_we),
        .state     (state),
        .instr_cnt (instr_cnt)
    );

    function automatic void e(input int st, input int pc, input int ir, input int rg,
                              input int mw, input int npc, input int rdst, input int wd,
                              input int src, input int aop, input int ext,
                              input bit rst = 1'b0, input bit rdy = 1'b1);
        rec_t r;
        r.st  = st[2:0];
        r.we  = {pc[0], ir[0], rg[0], mw[0]};
        r.sel = {npc[1:0], rdst[1:0], wd[1:0], src[0], aop[1:0], ext[0]};
        r.rst = rst;
        r.rdy = rdy;
        sb.push_back(r);
    endfunction

    // FETCH and supported-DECODE cycles look the same for every instruction.
    function automatic void fd();
        e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic run(input string tag, input logic [31:0] iw, input logic z);
        rec_t r;
        instr = iw;
        zero  = z;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            reset = r.rst;
`ifdef MC_CTRL_MEM_WAIT_EN
            mem_ready = r.rdy;
`endif
            @(negedge clk);
            checks++;
            assert (state === r.st) else begin
                errors++;
                $error("FAIL %s state c%0d: got %0d want %0d", tag, cyc, state, r.st);
            end
            checks++;
            assert ({pc_we, ir_we, reg_we, mem_we} === r.we) else begin
                errors++;
                $error("FAIL %s we c%0d: got %b want %b (pc,ir,reg,mem)", tag, cyc,
                       {pc_we, ir_we, reg_we, mem_we}, r.we);
            end
            checks++;
            assert ({npc_sel, reg_dst, wd_sel, alu_src, alu_op, ext_op} === r.sel) else begin
                errors++;
                $error("FAIL %s sel c%0d: got %b want %b (npc,dst,wd,src,op,ext)", tag, cyc,
                       {npc_sel, reg_dst, wd_sel, alu_src, alu_op, ext_op}, r.sel);
            end
            @(posedge clk);
            #1;
            cyc++;
            if (r.rst) exp_cnt = '0;
            else if (r.we[3]) exp_cnt = exp_cnt + 32'd1;
        end
        checks++;
        assert (instr_cnt === exp_cnt) else begin
            errors++;
            $error("FAIL %s instr_cnt: got %0d want %0d", tag, instr_cnt, exp_cnt);
        end
        $display("txn %-10s instr=%08h cycles=%0d instr_cnt=%0d", tag, iw, cyc, instr_cnt);
        cyc = 0;
    endtask

    initial begin
        reset = 1'b1;
        instr = '0;
        zero  = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        @(posedge clk);
        #1;

        // Two held reset cycles: state FETCH, every enable and select low.
        e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        run("reset", 32'h0, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 0,0,0); e(4, 1,0,1,0, 0,1,0, 0,0,0);
        run("addu", 32'h0022_1821, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 0,1,0); e(4, 1,0,1,0, 0,1,0, 0,1,0);
        run("subu", 32'h0022_1823, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 1,2,0); e(4, 1,0,1,0, 0,0,0, 1,2,0);
        run("ori", 32'h3401_1234, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 1,3,0); e(4, 1,0,1,0, 0,0,0, 1,3,0);
        run("lui", 32'h3C02_1234, 1'b0);

        fd(); e(2, 1,0,0,0, 1,0,0, 0,1,0);
        run("beq_z1", 32'h1022_0004, 1'b1);

        fd(); e(2, 1,0,0,0, 0,0,0, 0,1,0);
        run("beq_z0", 32'h1022_0004, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 1,0,1); e(3, 0,0,0,0, 0,0,0, 1,0,1);
        e(4, 1,0,1,0, 0,0,1, 1,0,1);
        run("lw", 32'h8C04_0008, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 1,0,1); e(3, 1,0,0,1, 0,0,0, 1,0,1);
        run("sw", 32'hAC04_000C, 1'b0);

        fd(); e(2, 1,0,0,0, 2,0,0, 0,0,0);
        run("j", 32'h0800_0C00, 1'b0);

        fd(); e(2, 1,0,1,0, 2,2,2, 0,0,0);
        run("jal", 32'h0C00_0C00, 1'b0);

        fd(); e(2, 1,0,0,0, 3,0,0, 0,0,0);
        run("jr", 32'h03E0_0008, 1'b0);

        e(0, 0,1,0,0, 0,0,0, 0,0,0); e(1, 1,0,0,0, 0,0,0, 0,0,0);
        run("unsup", 32'hFC00_0000, 1'b0);

        // Reset during EXEC: outputs forced low, counter cleared, back to FETCH.
        fd(); e(2, 0,0,0,0, 0,0,0, 0,0,0, 1'b1);
        run("addu_rst", 32'h0022_1821, 1'b0);

`ifdef MC_CTRL_MEM_WAIT_EN
        fd(); e(2, 0,0,0,0, 0,0,0, 1,0,1);
        e(3, 0,0,0,1, 0,0,0, 1,0,1, 1'b0, 1'b0);
        e(3, 0,0,0,1, 0,0,0, 1,0,1, 1'b0, 1'b0);
        e(3, 0,0,0,1, 0,0,0, 1,0,1, 1'b0, 1'b0);
        e(3, 1,0,0,1, 0,0,0, 1,0,1, 1'b0, 1'b1);
        run("sw_wait", 32'hAC04_000C, 1'b0);

        fd(); e(2, 0,0,0,0, 0,0,0, 1,0,1);
        e(3, 0,0,0,1, 0,0,0, 1,0,1, 1'b0, 1'b0);
        e(3, 0,0,0,0, 0,0,0, 0,0,0, 1'b1, 1'b0);
        run("sw_rst", 32'hAC04_000C, 1'b0);
`endif

        e(0, 0,1,0,0, 0,0,0, 0,0,0); e(1, 1,0,0,0, 0,0,0, 0,0,0);
        run("nop", 32'h0000_0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog so a stuck run still terminates.
    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
